// File: rtl/imem_loader_if.sv
// Byte-stream handshake between a program source and the imem loader.
`timescale 1ns/1ps
interface imem_loader_if;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;

   modport master (
      output byte_valid,
      output byte_data,
      input  byte_ready
   );

   modport slave (
      input  byte_valid,
      input  byte_data,
      output byte_ready
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: packs a little-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the CPU in reset until done.
`timescale 1ns/1ps
module imem_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   word_count,
   imem_loader_if.slave          bs,
   output logic                  imem_wr_en,
   output logic [ADDR_WIDTH-1:0] imem_wr_addr,
   output logic [31:0]           imem_wr_data,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WRITE,
      DONE
   } state_t;

   localparam logic [ADDR_WIDTH:0] MAX_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_t                state, state_n;
   logic [1:0]            byte_idx;
   logic [23:0]           buf_q;
   logic [ADDR_WIDTH:0]   word_cnt;
   logic [ADDR_WIDTH:0]   count_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  ready_q;
   logic                  accept;
   logic                  xfer;
   logic                  last;
   logic [ADDR_WIDTH:0]   count_sat;

   assign bs.byte_ready = ready_q;

   assign accept    = ((state == IDLE) || (state == DONE)) && start;
   assign xfer      = (state == LOAD) && bs.byte_valid;
   assign last      = (word_cnt + (ADDR_WIDTH+1)'(1)) == count_q;
   // Clamp so the word address can never wrap past the top of memory.
   assign count_sat = (word_count > MAX_CNT) ? MAX_CNT : word_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n = (word_count == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (bs.byte_valid && (byte_idx == 2'd3)) begin
               state_n = WRITE;
            end
         end
         WRITE: begin
            state_n = last ? DONE : LOAD;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_idx     <= '0;
         buf_q        <= '0;
         word_cnt     <= '0;
         count_q      <= '0;
         addr_q       <= '0;
         imem_wr_addr <= '0;
         imem_wr_data <= '0;
      end else begin
         if (accept) begin
            count_q  <= count_sat;
            addr_q   <= '0;
            byte_idx <= '0;
            word_cnt <= '0;
         end
         if (xfer) begin
            // Shifting in from the top leaves bytes 0..2 in LSB-first order.
            buf_q    <= {bs.byte_data, buf_q[23:8]};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
               imem_wr_data <= {bs.byte_data, buf_q};
               imem_wr_addr <= addr_q;
            end
         end
         if (state == WRITE) begin
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            word_cnt <= word_cnt + (ADDR_WIDTH+1)'(1);
            byte_idx <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_q    <= 1'b0;
         imem_wr_en <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cpu_reset  <= 1'b1;
      end else begin
         ready_q    <= (state_n == LOAD);
         imem_wr_en <= (state_n == WRITE);
         busy       <= (state_n == LOAD) || (state_n == WRITE);
         done       <= (state_n == DONE);
         cpu_reset  <= (state_n != DONE);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: default-width instance plus a
// 2-bit-address instance for count saturation.
`timescale 1ns/1ps
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start0 = 1'b0;
   logic       start1 = 1'b0;
   logic [8:0] wc0 = '0;
   logic [2:0] wc1 = '0;
   logic       valid = 1'b0;
   logic [7:0] data = '0;
   logic       sel = 1'b0;

   logic        wr_en0, cr0, busy0, done0;
   logic [7:0]  waddr0;
   logic [31:0] wdata0;
   logic        wr_en1, cr1, busy1, done1;
   logic [1:0]  waddr1;
   logic [31:0] wdata1;

   logic        wr_en_m, cr_m, busy_m, done_m, ready_m;
   logic [7:0]  waddr_m;
   logic [31:0] wdata_m;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int nw = 0;
   int hs = 0;
   int bad = 0;
   int rel_cyc = -1;
   logic prev_cr = 1'b1;
   logic [7:0]  wa [64];
   logic [31:0] wd [64];
   int          wcy [64];
   int e_cyc = 0;
   int base = 0;
   int h0 = 0;
   int b0 = 0;

   logic [7:0] prog [8] = '{8'h13, 8'h00, 8'h50, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00};

   imem_loader_if bus0 ();
   imem_loader_if bus1 ();

   assign bus0.byte_valid = valid;
   assign bus0.byte_data  = data;
   assign bus1.byte_valid = valid;
   assign bus1.byte_data  = data;

   imem_loader #(.ADDR_WIDTH(8)) u0 (
      .clk(clk), .reset(reset), .start(start0), .word_count(wc0),
      .bs(bus0), .imem_wr_en(wr_en0), .imem_wr_addr(waddr0),
      .imem_wr_data(wdata0), .cpu_reset(cr0), .busy(busy0), .done(done0)
   );

   imem_loader #(.ADDR_WIDTH(2)) u1 (
      .clk(clk), .reset(reset), .start(start1), .word_count(wc1),
      .bs(bus1), .imem_wr_en(wr_en1), .imem_wr_addr(waddr1),
      .imem_wr_data(wdata1), .cpu_reset(cr1), .busy(busy1), .done(done1)
   );

   assign wr_en_m = sel ? wr_en1 : wr_en0;
   assign cr_m    = sel ? cr1 : cr0;
   assign busy_m  = sel ? busy1 : busy0;
   assign done_m  = sel ? done1 : done0;
   assign ready_m = sel ? bus1.byte_ready : bus0.byte_ready;
   assign waddr_m = sel ? {6'b0, waddr1} : waddr0;
   assign wdata_m = sel ? wdata1 : wdata0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (valid && ready_m === 1'b1) hs <= hs + 1;
   end

   always @(negedge clk) begin
      if (wr_en_m === 1'b1) begin
         if (nw < 64) begin
            wa[nw]  <= waddr_m;
            wd[nw]  <= wdata_m;
            wcy[nw] <= cyc;
         end
         nw <= nw + 1;
         if (ready_m !== 1'b0) bad <= bad + 1;
      end
      if (prev_cr === 1'b1 && cr_m === 1'b0) rel_cyc <= cyc;
      prev_cr <= cr_m;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input int wc);
      @(negedge clk);
      if (sel) begin
         wc1 = 3'(wc);
         start1 = 1'b1;
      end else begin
         wc0 = 9'(wc);
         start0 = 1'b1;
      end
      @(posedge clk);
      #1;
      e_cyc = cyc;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic gap_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         valid = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      gap_cycles(gap);
      @(negedge clk);
      valid = 1'b1;
      data  = b;
      n = 0;
      while (ready_m !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("ready_timeout", 64'(ready_m), 64'd1);
      @(posedge clk);
   endtask

   task automatic stop_valid();
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done_m !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("done_reached", 64'(done_m), 64'd1);
      #2;
   endtask

   initial begin
      // Reset asserted mid-cycle, released 10 ns later
      #12 reset = 1'b1;
      #1;
      chk("rst_flags", {59'd0, cr0, bus0.byte_ready, wr_en0, busy0, done0},
          64'b10000);
      chk("rst_addr_data", {24'd0, waddr0, wdata0}, 64'd0);
      #9 reset = 1'b0;
      valid = 1'b1;
      data  = 8'hee;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_hold", {62'd0, cr0, bus0.byte_ready}, 64'b10);
      end
      valid = 1'b0;

      // Two-word load, byte_valid held high
      base = nw;
      h0 = hs;
      do_start(2);
      chk("start_outputs", {60'd0, busy_m, ready_m, cr_m, done_m},
          64'b1110);
      for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
      stop_valid();
      wait_done();
      chk("tw_count", 64'(nw - base), 64'd2);
      chk("tw_w0", {24'd0, wa[base], wd[base]}, {24'd0, 8'd0, 32'h00500013});
      chk("tw_w1", {24'd0, wa[base+1], wd[base+1]},
          {24'd0, 8'd1, 32'h00100093});
      chk("tw_first_lat", 64'(wcy[base] - e_cyc), 64'd4);
      chk("tw_spacing", 64'(wcy[base+1] - wcy[base]), 64'd5);
      chk("tw_release", 64'(rel_cyc - wcy[base+1]), 64'd1);
      chk("tw_done_out", {61'd0, cr_m, busy_m, ready_m}, 64'b000);

      // Same stream with 3-cycle gaps between bytes
      base = nw;
      h0 = hs;
      b0 = bad;
      do_start(2);
      for (int i = 0; i < 8; i++) send_byte(prog[i], 3);
      stop_valid();
      wait_done();
      chk("gap_count", 64'(nw - base), 64'd2);
      chk("gap_w0", {24'd0, wa[base], wd[base]},
          {24'd0, 8'd0, 32'h00500013});
      chk("gap_w1", {24'd0, wa[base+1], wd[base+1]},
          {24'd0, 8'd1, 32'h00100093});
      chk("gap_handshakes", 64'(hs - h0), 64'd8);
      chk("gap_ready_in_write", 64'(bad - b0), 64'd0);

      // Zero count, then reload one word
      base = nw;
      do_start(0);
      chk("zero_outputs", {60'd0, done_m, cr_m, busy_m, ready_m}, 64'b1000);
      repeat (3) @(negedge clk);
      #2;
      chk("zero_no_write", 64'(nw - base), 64'd0);
      do_start(1);
      chk("reload_outputs", {60'd0, done_m, cr_m, busy_m, ready_m},
          64'b0111);
      send_byte(8'h78, 0);
      send_byte(8'h56, 0);
      send_byte(8'h34, 0);
      send_byte(8'h12, 0);
      stop_valid();
      wait_done();
      chk("reload_count", 64'(nw - base), 64'd1);
      chk("reload_w0", {24'd0, wa[base], wd[base]},
          {24'd0, 8'd0, 32'h12345678});

      // Start pulsed during LOAD is ignored
      base = nw;
      do_start(1);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      stop_valid();
      @(negedge clk);
      wc0 = 9'd3;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      stop_valid();
      wait_done();
      chk("ign_count", 64'(nw - base), 64'd1);
      chk("ign_w0", {24'd0, wa[base], wd[base]},
          {24'd0, 8'd0, 32'h44332211});

      // Saturation on the 2-bit-address instance
      sel = 1'b1;
      base = nw;
      do_start(7);
      for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 0);
      stop_valid();
      wait_done();
      chk("sat_count", 64'(nw - base), 64'd4);
      chk("sat_addrs", {32'd0, wa[base], wa[base+1], wa[base+2], wa[base+3]},
          {32'd0, 8'd0, 8'd1, 8'd2, 8'd3});
      chk("sat_w0", 64'(wd[base]), 64'h04030201);
      chk("sat_w3", 64'(wd[base+3]), 64'h100f0e0d);
      chk("sat_done_out", {62'd0, cr_m, busy_m}, 64'b00);
      sel = 1'b0;

      // Reset after two bytes of word 1
      base = nw;
      do_start(2);
      for (int i = 0; i < 4; i++) send_byte(prog[i], 0);
      send_byte(8'haa, 0);
      send_byte(8'hbb, 0);
      stop_valid();
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_flags",
          {59'd0, cr0, bus0.byte_ready, wr_en0, busy0, done0}, 64'b10000);
      chk("mid_rst_addr_data", {24'd0, waddr0, wdata0}, 64'd0);
      #9 reset = 1'b0;
      chk("mid_pre_count", 64'(nw - base), 64'd1);
      base = nw;
      do_start(1);
      send_byte(8'hcc, 0);
      send_byte(8'hdd, 0);
      send_byte(8'hee, 0);
      send_byte(8'hff, 0);
      stop_valid();
      wait_done();
      chk("mid_new_count", 64'(nw - base), 64'd1);
      chk("mid_new_w0", {24'd0, wa[base], wd[base]},
          {24'd0, 8'd0, 32'hffeeddcc});

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory writer for the 32-bit RISC CPU. It accepts a byte stream over a valid/ready handshake, packs each group of four bytes little-endian into a 32-bit word, and writes the words to consecutive instruction-memory addresses starting at 0. It holds the CPU in reset until the programmed word count has been written, then releases it. The block sits between the program source (bench or UART front end) and the `cpu_top_module` instruction memory write port.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 8: word-address width. Memory depth is 2^ADDR_WIDTH words.

**Ports**
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `start`: input, 1 bit. Single-cycle request to begin a load. Sampled only in IDLE or DONE.
- `word_count`: input, ADDR_WIDTH+1 bits. Number of words to load. Latched when `start` is accepted.
- `byte_valid`: input, 1 bit. Source has a byte on `byte_data`.
- `byte_data`: input, 8 bits. Program byte.
- `byte_ready`: output, 1 bit. Loader accepts a byte this cycle.
- `imem_wr_en`: output, 1 bit. Instruction memory write strobe, one cycle per word.
- `imem_wr_addr`: output, ADDR_WIDTH bits. Word address for the write.
- `imem_wr_data`: output, 32 bits. Packed word.
- `cpu_reset`: output, 1 bit. Active-high reset to the CPU core.
- `busy`: output, 1 bit. High in LOAD and WRITE.
- `done`: output, 1 bit. High in DONE. Sticky until the next accepted `start`.

## Operation

**Reset values**
- `cpu_reset`=1, `byte_ready`=0, `imem_wr_en`=0, `imem_wr_addr`=0, `imem_wr_data`=0, `busy`=0, `done`=0.
- State = IDLE, byte index = 0, word counter = 0.

**States**
- IDLE (after reset)
  - `start` with `word_count`≠0: go to LOAD, address = 0.
  - `start` with `word_count`=0: go directly to DONE, with no writes.
- LOAD
  - `byte_ready`=1.
  - A byte transfers on any edge where `byte_valid` and `byte_ready` are both high.
  - Byte index k (0..3) goes to word bits [8k+7:8k]. The first byte is the LSB.
  - When the transfer with k=3 occurs, go to WRITE.
- WRITE (one cycle)
  - `imem_wr_en`=1, `byte_ready`=0.
  - On exit, the address increments and the word counter increments.
  - If counter+1 equals the latched count, go to DONE. Otherwise go to LOAD with byte index 0.
- DONE
  - `cpu_reset`=0, `done`=1, `byte_ready`=0.
  - `start` reasserts `cpu_reset`, clears `done`, resets address and byte index, and re-enters LOAD, or stays in DONE if `word_count`=0.

**Rules**
- `start` is ignored in LOAD and WRITE.
- `byte_valid` is ignored outside LOAD.
- `cpu_reset`=1 in IDLE, LOAD and WRITE.
- `word_count` values above 2^ADDR_WIDTH saturate to 2^ADDR_WIDTH when latched, so the address never wraps.
- The last write goes to address 2^ADDR_WIDTH−1.
- Partial words are never written. Fewer than four bytes leaves the block in LOAD indefinitely.
- `imem_wr_addr` and `imem_wr_data` are stable for the whole WRITE cycle. Outside WRITE they hold their last values.
- Reset asserted in any state returns all outputs to their reset values immediately (asynchronously). This includes re-asserting `cpu_reset`. Partially assembled bytes are discarded.

## Timing

- All outputs are registered.
- `start` accepted at edge E: `byte_ready`=1 and `busy`=1 from E.
- Fourth byte accepted at edge B: `imem_wr_en`=1 for exactly the cycle between B and B+1, with `byte_ready`=0 in that cycle.
  - If not the last word, `byte_ready` returns to 1 at B+1.
  - Minimum throughput: 5 cycles per word (4 byte cycles plus 1 write cycle).
- Last WRITE ends at edge D: `cpu_reset` falls, `done` rises and `busy` falls at D.
- `word_count`=0 start at E: DONE entered at E.
- Release of reset is synchronous to `clk`. Assertion is asynchronous.

## Test plan

- **Reset:** assert `reset` mid-cycle, then release after 10 ns.
  - All outputs at their reset values.
  - `cpu_reset`=1 and `byte_ready`=0 until `start`.
- **Two-word load:** `word_count`=2, `start`, then bytes 13,00,50,00 and 93,00,10,00 (hex) with `byte_valid` held high.
  - Writes 00500013 to address 0, then 00100093 to address 1.
  - Each write 5 cycles apart.
  - `cpu_reset` falls on the edge after the second write.
- **Back-pressure and gaps:** same stream with `byte_valid` low for 3 cycles between every byte.
  - Identical write data and addresses.
  - No byte is lost or duplicated.
  - `byte_ready`=0 during each WRITE cycle.
- **Zero count and re-load:**
  - `word_count`=0 → DONE with no `imem_wr_en` and `cpu_reset`=0.
  - Then `start` with `word_count`=1 → `cpu_reset`=1 again, `done`=0, and a write to address 0.
- **Ignored start and saturation:**
  - `start` pulsed during LOAD has no effect.
  - With ADDR_WIDTH=2 and `word_count`=7: exactly 4 writes, to addresses 0..3, then DONE.
- **Reset mid-load:** assert `reset` after 2 bytes of word 1 (word 0 already written).
  - Outputs return to reset values immediately.
  - A new load starts at address 0 with byte index 0.
